rf68000_ext_seq: RTL and testbench



---
 rtl/rf68000_pkg.sv | 42 ++++
 rtl/rf68000_ext_seq_if.sv | 40 ++++
 rtl/rf68000_ext_slot.sv | 31 +++
 rtl/rf68000_ext_seq.sv | 120 ++++++++++++
 tb/tb_rf68000_ext_seq.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/rf68000_pkg.sv
// Shared types and the extension-word count rule for the rf68000 front end.
package rf68000_pkg;

    localparam int unsigned WORDW = 16;

    typedef struct packed {
        logic [1:0] sz;
        logic [2:0] m;
        logic [2:0] x;
    } ea_desc_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SRC,
        ST_DST,
        ST_DONE
    } ext_seq_state_e;

    // Extension words needed by one EA (byte length of the extension / 2).
    function automatic logic [1:0] mx_words(input logic [1:0] sz,
                                            input logic [2:0] m,
                                            input logic [2:0] x);
        logic [1:0] n;
        n = '0;
        case (m)
            3'd5, 3'd6: n = 2'd1;
            3'd7: begin
                case (x)
                    3'd0:    n = 2'd1;
                    3'd1:    n = 2'd2;
                    3'd2:    n = 2'd1;
                    3'd3:    n = 2'd1;
                    3'd4:    n = (sz == 2'd2) ? 2'd2 : 2'd1;
                    default: n = '0;
                endcase
            end
            default: n = '0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/rf68000_ext_seq_if.sv
// Decoder / instruction-stream / dispatch signals of the extension-word sequencer.
interface rf68000_ext_seq_if;
    import rf68000_pkg::*;

    logic             flush_i;
    logic             req_valid_i;
    logic             req_ready_o;
    logic [1:0]       sz_i;
    logic             src_en_i;
    logic             dst_en_i;
    logic [2:0]       src_m_i;
    logic [2:0]       src_x_i;
    logic [2:0]       dst_m_i;
    logic [2:0]       dst_x_i;
    logic             iw_valid_i;
    logic [WORDW-1:0] iw_i;
    logic             iw_ready_o;
    logic             done_valid_o;
    logic             done_ready_i;
    logic [31:0]      src_ext_o;
    logic [31:0]      dst_ext_o;
    logic [1:0]       src_nw_o;
    logic [1:0]       dst_nw_o;
    logic [2:0]       total_nw_o;

    modport slave (
        input  flush_i, req_valid_i, sz_i, src_en_i, dst_en_i,
               src_m_i, src_x_i, dst_m_i, dst_x_i, iw_valid_i, iw_i, done_ready_i,
        output req_ready_o, iw_ready_o, done_valid_o,
               src_ext_o, dst_ext_o, src_nw_o, dst_nw_o, total_nw_o
    );

    modport master (
        output flush_i, req_valid_i, sz_i, src_en_i, dst_en_i,
               src_m_i, src_x_i, dst_m_i, dst_x_i, iw_valid_i, iw_i, done_ready_i,
        input  req_ready_o, iw_ready_o, done_valid_o,
               src_ext_o, dst_ext_o, src_nw_o, dst_nw_o, total_nw_o
    );

endinterface

// File: rtl/rf68000_ext_slot.sv
// One EA's extension register: holds its word count and shifts words in first-high.
module rf68000_ext_slot
    import rf68000_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [1:0]       nw_i,
    input  logic             shift_i,
    input  logic [WORDW-1:0] word_i,
    output logic [31:0]      ext_o,
    output logic [1:0]       nw_o
);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ext_o <= '0;
            nw_o  <= '0;
        end else if (clr_i) begin
            ext_o <= '0;
            nw_o  <= '0;
        end else if (load_i) begin
            ext_o <= '0;
            nw_o  <= nw_i;
        end else if (shift_i) begin
            ext_o <= {ext_o[31-WORDW:0], word_i};
        end
    end

endmodule

// File: rtl/rf68000_ext_seq.sv
// Extension-word sequencer: counts, fetches and assembles src/dst EA extension words.
module rf68000_ext_seq
    import rf68000_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_ni,
    rf68000_ext_seq_if.slave     bus
);

    ext_seq_state_e state_q, state_d;
    logic [1:0]     wcnt_q, wcnt_d;
    ea_desc_t       src_ea, dst_ea;
    logic [1:0]     src_req_nw, dst_req_nw;
    logic [1:0]     src_nw, dst_nw;
    logic [31:0]    src_ext, dst_ext;
    logic           load, clr, src_shift, dst_shift;

    assign src_ea = '{sz: bus.sz_i, m: bus.src_m_i, x: bus.src_x_i};
    assign dst_ea = '{sz: bus.sz_i, m: bus.dst_m_i, x: bus.dst_x_i};

    assign src_req_nw = bus.src_en_i ? mx_words(src_ea.sz, src_ea.m, src_ea.x) : '0;
    assign dst_req_nw = bus.dst_en_i ? mx_words(dst_ea.sz, dst_ea.m, dst_ea.x) : '0;

    // Handshake readies depend on state only; flush is the single input that masks them.
    assign bus.req_ready_o  = (state_q == ST_IDLE) && !bus.flush_i;
    assign bus.iw_ready_o   = ((state_q == ST_SRC) || (state_q == ST_DST)) && !bus.flush_i;
    assign bus.done_valid_o = (state_q == ST_DONE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        load      = 1'b0;
        clr       = 1'b0;
        src_shift = 1'b0;
        dst_shift = 1'b0;
        if (bus.flush_i) begin
            state_d = ST_IDLE;
            wcnt_d  = '0;
            clr     = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.req_valid_i) begin
                        load = 1'b1;
                        if (src_req_nw != '0)      state_d = ST_SRC;
                        else if (dst_req_nw != '0) state_d = ST_DST;
                        else                       state_d = ST_DONE;
                    end
                end
                ST_SRC: begin
                    if (bus.iw_valid_i) begin
                        src_shift = 1'b1;
                        if (wcnt_q + 2'd1 == src_nw) begin
                            wcnt_d  = '0;
                            state_d = (dst_nw != '0) ? ST_DST : ST_DONE;
                        end else begin
                            wcnt_d = wcnt_q + 2'd1;
                        end
                    end
                end
                ST_DST: begin
                    if (bus.iw_valid_i) begin
                        dst_shift = 1'b1;
                        if (wcnt_q + 2'd1 == dst_nw) begin
                            wcnt_d  = '0;
                            state_d = ST_DONE;
                        end else begin
                            wcnt_d = wcnt_q + 2'd1;
                        end
                    end
                end
                ST_DONE: begin
                    if (bus.done_ready_i) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    rf68000_ext_slot u_src_slot (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clr_i   (clr),
        .load_i  (load),
        .nw_i    (src_req_nw),
        .shift_i (src_shift),
        .word_i  (bus.iw_i),
        .ext_o   (src_ext),
        .nw_o    (src_nw)
    );

    rf68000_ext_slot u_dst_slot (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clr_i   (clr),
        .load_i  (load),
        .nw_i    (dst_req_nw),
        .shift_i (dst_shift),
        .word_i  (bus.iw_i),
        .ext_o   (dst_ext),
        .nw_o    (dst_nw)
    );

    assign bus.src_ext_o  = src_ext;
    assign bus.dst_ext_o  = dst_ext;
    assign bus.src_nw_o   = src_nw;
    assign bus.dst_nw_o   = dst_nw;
    assign bus.total_nw_o = {1'b0, src_nw} + {1'b0, dst_nw};

endmodule

// File: tb/tb_rf68000_ext_seq.sv
// Scoreboard bench for rf68000_ext_seq: directed test-plan cases plus a short random run.
module tb_rf68000_ext_seq;
    import rf68000_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rf68000_ext_seq_if bus();

    rf68000_ext_seq dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    typedef struct {
        logic [31:0] se;
        logic [31:0] de;
        int          sn;
        int          dn;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", tag, act, exp);
        end
    endtask

    function automatic int exp_nw(input logic en, input logic [1:0] sz,
                                  input logic [2:0] m, input logic [2:0] x);
        if (!en || m < 3'd5) return 0;
        if (m != 3'd7) return 1;
        case (x)
            3'd1:             return 2;
            3'd4:             return (sz == 2'd2) ? 2 : 1;
            3'd5, 3'd6, 3'd7: return 0;
            default:          return 1;
        endcase
    endfunction

    function automatic logic [31:0] exp_ext(input int n, input logic [15:0] a, input logic [15:0] b);
        if (n == 0) return 32'h0;
        if (n == 1) return {16'h0, a};
        return {a, b};
    endfunction

    // Scoreboard side: every completed DONE handshake must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && bus.done_valid_o === 1'b1 && bus.done_ready_i === 1'b1) begin
            if (sbq.size() == 0) begin
                check_eq("sb_unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check_eq("sb_src_ext", bus.src_ext_o, e.se);
                check_eq("sb_dst_ext", bus.dst_ext_o, e.de);
                check_eq("sb_src_nw", bus.src_nw_o, e.sn);
                check_eq("sb_dst_nw", bus.dst_nw_o, e.dn);
                check_eq("sb_total_nw", bus.total_nw_o, e.sn + e.dn);
            end
        end
    end

    task automatic drive_req(input logic [1:0] sz, input logic se, input logic [2:0] sm,
                             input logic [2:0] sx, input logic de, input logic [2:0] dm,
                             input logic [2:0] dx);
        bus.req_valid_i = 1'b1;
        bus.sz_i     = sz;
        bus.src_en_i = se;
        bus.src_m_i  = sm;
        bus.src_x_i  = sx;
        bus.dst_en_i = de;
        bus.dst_m_i  = dm;
        bus.dst_x_i  = dx;
    endtask

    task automatic do_req(input logic [1:0] sz, input logic se, input logic [2:0] sm,
                          input logic [2:0] sx, input logic de, input logic [2:0] dm,
                          input logic [2:0] dx, input int stall, input int hold,
                          input logic [15:0] w0, input logic [15:0] w1,
                          input logic [15:0] w2, input logic [15:0] w3);
        logic [15:0] wv[4];
        int n_s, n_d, n, st, k, t_acc;
        exp_t e;
        wv[0] = w0; wv[1] = w1; wv[2] = w2; wv[3] = w3;
        n_s = exp_nw(se, sz, sm, sx);
        n_d = exp_nw(de, sz, dm, dx);
        n   = n_s + n_d;
        st  = (n > 0) ? stall : 0;
        e.se = exp_ext(n_s, wv[0], wv[1]);
        e.de = exp_ext(n_d, wv[n_s], wv[n_s + 1]);
        e.sn = n_s;
        e.dn = n_d;

        @(posedge clk); #1;
        k = 0;
        while (bus.req_ready_o !== 1'b1 && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        if (k == 50) check_eq("req_ready_wait", bus.req_ready_o, 1);
        sbq.push_back(e);
        drive_req(sz, se, sm, sx, de, dm, dx);
        @(posedge clk); #1;
        bus.req_valid_i = 1'b0;
        t_acc = cyc;

        for (int i = 0; i < n; i++) begin
            if (i == 0) begin
                repeat (st) begin
                    bus.iw_valid_i = 1'b0;
                    bus.iw_i = 16'hFFFF;
                    @(negedge clk);
                    check_eq("stall_iw_ready", bus.iw_ready_o, 1);
                    @(posedge clk); #1;
                end
            end
            bus.iw_valid_i = 1'b1;
            bus.iw_i = wv[i];
            @(negedge clk);
            check_eq("word_iw_ready", bus.iw_ready_o, 1);
            @(posedge clk); #1;
        end
        bus.iw_valid_i = 1'b0;

        @(negedge clk);
        k = 0;
        while (bus.done_valid_o !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        check_eq("done_latency", cyc - t_acc, n + st);
        check_eq("done_iw_ready", bus.iw_ready_o, 0);

        for (int h = 0; h < hold; h++) begin
            check_eq("hold_done_valid", bus.done_valid_o, 1);
            check_eq("hold_req_ready", bus.req_ready_o, 0);
            check_eq("hold_src_ext", bus.src_ext_o, e.se);
            check_eq("hold_dst_ext", bus.dst_ext_o, e.de);
            @(negedge clk);
        end

        @(posedge clk); #1;
        bus.done_ready_i = 1'b1;
        @(posedge clk); #1;
        bus.done_ready_i = 1'b0;
        @(negedge clk);
        check_eq("post_done_req_ready", bus.req_ready_o, 1);
        check_eq("post_done_valid", bus.done_valid_o, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout actual=%0d required=finish", cyc);
        $fatal(1);
    end

    initial begin
        bus.flush_i = 1'b0;
        bus.req_valid_i = 1'b0;
        bus.sz_i = '0;
        bus.src_en_i = 1'b0;
        bus.dst_en_i = 1'b0;
        bus.src_m_i = '0;
        bus.src_x_i = '0;
        bus.dst_m_i = '0;
        bus.dst_x_i = '0;
        bus.iw_valid_i = 1'b0;
        bus.iw_i = '0;
        bus.done_ready_i = 1'b0;

        #12;
        check_eq("rst_req_ready", bus.req_ready_o, 1);
        check_eq("rst_iw_ready", bus.iw_ready_o, 0);
        check_eq("rst_done_valid", bus.done_valid_o, 0);
        check_eq("rst_src_ext", bus.src_ext_o, 0);
        check_eq("rst_dst_ext", bus.dst_ext_o, 0);
        check_eq("rst_total_nw", bus.total_nw_o, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // (d16,An) source, no destination
        do_req(2'd1, 1, 3'd5, 3'd0, 0, 3'd0, 3'd0, 0, 0, 16'h1234, 16'h0, 16'h0, 16'h0);
        // #imm.L source, abs.L destination
        do_req(2'd2, 1, 3'd7, 3'd4, 1, 3'd7, 3'd1, 0, 0, 16'hDEAD, 16'hBEEF, 16'h0001, 16'h0000);
        // Dn to Dn
        do_req(2'd1, 1, 3'd0, 3'd2, 1, 3'd0, 3'd3, 0, 0, 16'h0, 16'h0, 16'h0, 16'h0);
        // three-cycle stream stall before the word
        do_req(2'd1, 1, 3'd5, 3'd0, 0, 3'd0, 3'd0, 3, 0, 16'h1234, 16'h0, 16'h0, 16'h0);

        // flush after first of four words
        @(posedge clk); #1;
        drive_req(2'd2, 1, 3'd7, 3'd4, 1, 3'd7, 3'd1);
        @(posedge clk); #1;
        bus.req_valid_i = 1'b0;
        bus.iw_valid_i = 1'b1;
        bus.iw_i = 16'hDEAD;
        @(negedge clk);
        check_eq("fl_first_iw_ready", bus.iw_ready_o, 1);
        @(posedge clk); #1;
        bus.flush_i = 1'b1;
        bus.iw_i = 16'hBEEF;
        bus.req_valid_i = 1'b1;
        @(negedge clk);
        check_eq("fl_iw_ready", bus.iw_ready_o, 0);
        check_eq("fl_req_ready", bus.req_ready_o, 0);
        check_eq("fl_done_valid", bus.done_valid_o, 0);
        @(posedge clk); #1;
        bus.flush_i = 1'b0;
        bus.req_valid_i = 1'b0;
        bus.iw_valid_i = 1'b0;
        @(negedge clk);
        check_eq("fl_idle_req_ready", bus.req_ready_o, 1);
        check_eq("fl_idle_done_valid", bus.done_valid_o, 0);
        do_req(2'd2, 1, 3'd7, 3'd4, 1, 3'd7, 3'd1, 0, 0, 16'hDEAD, 16'hBEEF, 16'h0001, 16'h0000);

        // dispatch back-pressure in DONE
        do_req(2'd1, 1, 3'd5, 3'd0, 0, 3'd0, 3'd0, 0, 5, 16'h1234, 16'h0, 16'h0, 16'h0);
        // #imm.B source (one word, k8 low byte), d8 index destination
        do_req(2'd0, 1, 3'd7, 3'd4, 1, 3'd6, 3'd3, 0, 0, 16'h00A5, 16'h3C10, 16'h0, 16'h0);
        // abs.W source, d16(PC) destination, word size
        do_req(2'd1, 1, 3'd7, 3'd0, 1, 3'd7, 3'd2, 1, 2, 16'h8001, 16'h7FFE, 16'h0, 16'h0);
        // reserved m=7/x=5 source, disabled-but-m5 pattern, only destination fetches
        do_req(2'd2, 1, 3'd7, 3'd5, 1, 3'd7, 3'd3, 0, 0, 16'h4242, 16'h0, 16'h0, 16'h0);
        do_req(2'd2, 0, 3'd5, 3'd0, 1, 3'd7, 3'd4, 0, 0, 16'hCAFE, 16'hF00D, 16'h0, 16'h0);

        // asynchronous reset in the middle of a sequence
        @(posedge clk); #1;
        drive_req(2'd2, 1, 3'd7, 3'd4, 1, 3'd7, 3'd1);
        @(posedge clk); #1;
        bus.req_valid_i = 1'b0;
        bus.iw_valid_i = 1'b1;
        bus.iw_i = 16'hDEAD;
        @(posedge clk); #1;
        bus.iw_valid_i = 1'b0;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_src_ext", bus.src_ext_o, 0);
        check_eq("mid_rst_src_nw", bus.src_nw_o, 0);
        check_eq("mid_rst_req_ready", bus.req_ready_o, 1);
        check_eq("mid_rst_iw_ready", bus.iw_ready_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        do_req(2'd1, 1, 3'd5, 3'd0, 0, 3'd0, 3'd0, 0, 0, 16'h5678, 16'h0, 16'h0, 16'h0);

        for (int r = 0; r < 10; r++) begin
            do_req(2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                   3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                   1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                   3'($urandom_range(0, 7)), $urandom_range(0, 2), $urandom_range(0, 2),
                   16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
        end

        repeat (3) @(negedge clk);
        check_eq("sb_drained", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
